cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-low (0 = reset).
REQ-004 SHALL have port rdy, input, 1 bit: global enable; 0 freezes all state.
REQ-005 SHALL have port rollback, input, 1 bit: misprediction flush.
REQ-006 SHALL have ports alu_valid (input, 1), alu_rob_entry (input, 4) and alu_value (input, 32): ALU result offer.
REQ-007 SHALL have port alu_ready, output, 1 bit: the ALU queue can accept an offer.
REQ-008 SHALL have ports lsb_valid (input, 1), lsb_rob_entry (input, 4) and lsb_value (input, 32): LSB result offer.
REQ-009 SHALL have port lsb_ready, output, 1 bit: the LSB queue can accept an offer.
REQ-010 SHALL have ports cdb_valid (output, 1), cdb_src (output, 1; 0=ALU, 1=LSB), cdb_rob_entry (output, 4) and cdb_value (output, 32): the single common-data-bus broadcast to ROB, RS, LSB and decoder.

Function
REQ-011 SHALL keep one 2-deep FIFO per source, each entry holding {rob_entry, value}.
REQ-012 SHALL drive x_ready = (count_x < 2), decoded from registered count only, never from the same-cycle pop.
REQ-013 SHALL push at a rising edge when rst=1, rdy=1, rollback=0, x_valid=1 and x_ready=1.
REQ-014 SHALL perform at most one pop (grant) per edge when rst=1, rdy=1 and rollback=0.
REQ-015 Grant rule: both FIFOs non-empty -> grant the source != last_grant; exactly one non-empty -> grant it; both empty -> no grant.
REQ-016 SHALL update last_grant only on a grant.
REQ-017 On a grant, SHALL register cdb_valid=1, cdb_src=granted source, and cdb_rob_entry/cdb_value = that FIFO's head.
REQ-018 With no grant, SHALL register cdb_valid=0 and cdb_src/cdb_rob_entry/cdb_value=0.
REQ-019 Latency: an offer accepted at edge E SHALL appear on cdb_* after edge E+1 at the earliest; same-edge push-to-broadcast bypass is forbidden.
REQ-020 SHALL allow push and pop on the same source at the same edge; count is unchanged and FIFO order is preserved.
REQ-021 A full FIFO SHALL accept no push (ready=0), even if it is popped that edge.
REQ-022 Rollback=1 (rst=1, rdy=1) SHALL, at that edge, empty both FIFOs, register cdb_valid=0 with zero fields, and ignore pushes; last_grant SHALL be unchanged.
REQ-023 rdy=0 SHALL hold every register, including cdb_* outputs, and no push or pop SHALL occur.
REQ-024 FIFO read/write pointers SHALL be 1 bit each and wrap modulo 2; count SHALL be 2 bits, range 0..2.

Reset
REQ-025 On rst=0 at a rising edge, SHALL clear both FIFOs (count=0, pointers=0) and set last_grant=LSB, so ALU wins the first tie.
REQ-026 Reset outputs SHALL be cdb_valid=0, cdb_src=0, cdb_rob_entry=0, cdb_value=0; alu_ready=lsb_ready=1 in the following cycle.
REQ-027 Reset SHALL override rdy and rollback; a reset mid-operation SHALL discard all queued results.

Structure
REQ-028 A shared package SHALL hold: ROB_IDX_W=4, XLEN=32, CDB_FIFO_DEPTH=2, CDB_SRC_ALU=0, CDB_SRC_LSB=1.
REQ-029 SHALL instantiate one sub-module, cdb_src_fifo (2-entry FIFO with push/pop/flush/count), twice.
REQ-030 Arbitration and output registers SHALL live in cdb_arbiter; the block SHALL contain no other sub-modules.

Verification
REQ-031 Single offer: ALU offers {3, 0x11} at edge 1, LSB idle -> after edge 2, cdb_valid=1, src=0, entry=3, value=0x11; after edge 3, cdb_valid=0.
REQ-032 Tie after reset: both sources offer at edge 1 (ALU {1, 0xA}, LSB {2, 0xB}) -> after edge 2, ALU {1, 0xA}; after edge 3, LSB {2, 0xB}.
REQ-033 Backpressure: hold ALU valid for 3 cycles while LSB keeps winning -> alu_ready=0 once count=2, and no third entry is lost or duplicated.
REQ-034 Rollback: 2 entries queued in each FIFO, rollback=1 for one edge -> cdb_valid=0 for the next cycle, both readys=1, and no stale entry is ever broadcast.
REQ-035 rdy freeze: drop rdy for 4 cycles while cdb_valid=1 with {5, 0x55} -> outputs hold {5, 0x55} and broadcast resumes in order after rdy=1.
REQ-036 Reset mid-stream: rst=0 with both FIFOs full -> cdb_* all zero and next tie granted to ALU.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
//   ROB_IDX_W / XLEN  : widths of the ROB tag and result value
//   CDB_FIFO_DEPTH    : entries per source queue
//   CDB_SRC_ALU/LSB   : encoding of cdb_src
package cdb_arbiter_pkg;

  localparam int   ROB_IDX_W      = 4;
  localparam int   XLEN           = 32;
  localparam int   CDB_FIFO_DEPTH = 2;
  localparam logic CDB_SRC_ALU    = 1'b0;
  localparam logic CDB_SRC_LSB    = 1'b1;

  typedef logic [1:0] cdb_cnt_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [XLEN-1:0]      value;
  } cdb_entry_t;

  typedef enum logic {
    GRANT_ALU = CDB_SRC_ALU,
    GRANT_LSB = CDB_SRC_LSB
  } cdb_src_e;

  // A queue can take an offer only while it is below depth.
  function automatic logic fifo_has_room(input cdb_cnt_t count);
    return count < cdb_cnt_t'(CDB_FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-offer and broadcast bundle of the CDB arbiter.
//   alu_*   : ALU result offer (valid/rob_entry/value) and its ready
//   lsb_*   : LSB result offer (valid/rob_entry/value) and its ready
//   cdb_*   : registered broadcast (valid/src/rob_entry/value)
//   slave   : arbiter side; master : producer/consumer side
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic                 alu_valid;
  logic [ROB_IDX_W-1:0] alu_rob_entry;
  logic [XLEN-1:0]      alu_value;
  logic                 alu_ready;

  logic                 lsb_valid;
  logic [ROB_IDX_W-1:0] lsb_rob_entry;
  logic [XLEN-1:0]      lsb_value;
  logic                 lsb_ready;

  logic                 cdb_valid;
  logic                 cdb_src;
  logic [ROB_IDX_W-1:0] cdb_rob_entry;
  logic [XLEN-1:0]      cdb_value;

  modport slave (
    input  alu_valid, alu_rob_entry, alu_value,
    input  lsb_valid, lsb_rob_entry, lsb_value,
    output alu_ready, lsb_ready,
    output cdb_valid, cdb_src, cdb_rob_entry, cdb_value
  );

  modport master (
    output alu_valid, alu_rob_entry, alu_value,
    output lsb_valid, lsb_rob_entry, lsb_value,
    input  alu_ready, lsb_ready,
    input  cdb_valid, cdb_src, cdb_rob_entry, cdb_value
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Two-entry result queue for one CDB source.
//   clk, rst  : clock, synchronous active-low reset
//   rdy       : global enable, 0 holds all state
//   flush     : empties the queue and blocks push/pop this edge
//   push/data : enqueue request (ignored when full, even if popped)
//   pop       : dequeue request (ignored when empty)
//   head      : oldest entry
//   count     : occupancy, 0..2
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  input  logic       push,
  input  cdb_entry_t push_data,
  input  logic       pop,
  output cdb_entry_t head,
  output cdb_cnt_t   count
);

  cdb_entry_t mem [CDB_FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  cdb_cnt_t   count_q;
  logic       do_push;
  logic       do_pop;

  // Room is judged on the registered count, so a pop on the same edge
  // never opens a slot for a push.
  assign do_push = push && fifo_has_room(count_q) && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;

  assign head  = mem[rd_ptr];
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        count_q <= '0;
      end else begin
        if (do_push) wr_ptr <= ~wr_ptr;
        if (do_pop)  rd_ptr <= ~rd_ptr;
        if (do_push && !do_pop)      count_q <= count_q + 2'd1;
        else if (do_pop && !do_push) count_q <= count_q - 2'd1;
      end
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (rst && rdy && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: queues ALU and LSB results and broadcasts at
// most one per cycle, round-robin on ties.
//   clk, rst  : clock, synchronous active-low reset
//   rdy       : global enable, 0 freezes every register
//   rollback  : flush both queues and the broadcast register
//   bus       : offers in, readys and registered cdb_* broadcast out
//
// last_grant state | meaning
//   GRANT_ALU      | ALU won the most recent grant; LSB wins next tie
//   GRANT_LSB      | LSB won the most recent grant (or reset); ALU wins next tie
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rollback,
  cdb_arbiter_if.slave  bus
);

  cdb_entry_t alu_push_data, lsb_push_data;
  cdb_entry_t alu_head, lsb_head;
  cdb_cnt_t   alu_count, lsb_count;
  logic       alu_empty, lsb_empty;
  logic       alu_ready, lsb_ready;
  logic       alu_push, lsb_push;
  logic       alu_pop, lsb_pop;

  cdb_src_e   last_grant_q, last_grant_d;
  logic       grant_valid;
  cdb_src_e   grant_src;
  cdb_entry_t grant_data;

  logic                 cdb_valid_q;
  cdb_src_e             cdb_src_q;
  logic [ROB_IDX_W-1:0] cdb_rob_entry_q;
  logic [XLEN-1:0]      cdb_value_q;

  assign alu_push_data = '{rob_entry: bus.alu_rob_entry, value: bus.alu_value};
  assign lsb_push_data = '{rob_entry: bus.lsb_rob_entry, value: bus.lsb_value};

  assign alu_ready = fifo_has_room(alu_count);
  assign lsb_ready = fifo_has_room(lsb_count);
  assign alu_empty = (alu_count == '0);
  assign lsb_empty = (lsb_count == '0);

  assign alu_push = bus.alu_valid && alu_ready && !rollback;
  assign lsb_push = bus.lsb_valid && lsb_ready && !rollback;
  assign alu_pop  = grant_valid && (grant_src == GRANT_ALU);
  assign lsb_pop  = grant_valid && (grant_src == GRANT_LSB);

  cdb_src_fifo u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (rollback),
    .push      (alu_push),
    .push_data (alu_push_data),
    .pop       (alu_pop),
    .head      (alu_head),
    .count     (alu_count)
  );

  cdb_src_fifo u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (rollback),
    .push      (lsb_push),
    .push_data (lsb_push_data),
    .pop       (lsb_pop),
    .head      (lsb_head),
    .count     (lsb_count)
  );

  // Grant is decided from registered occupancy only, so an offer pushed
  // this edge can never be broadcast on the same edge.
  always_comb begin
    grant_valid  = 1'b0;
    grant_src    = GRANT_ALU;
    last_grant_d = last_grant_q;
    if (!rollback) begin
      if (!alu_empty && !lsb_empty) begin
        grant_valid = 1'b1;
        grant_src   = (last_grant_q == GRANT_ALU) ? GRANT_LSB : GRANT_ALU;
      end else if (!alu_empty) begin
        grant_valid = 1'b1;
        grant_src   = GRANT_ALU;
      end else if (!lsb_empty) begin
        grant_valid = 1'b1;
        grant_src   = GRANT_LSB;
      end
    end
    if (grant_valid) last_grant_d = grant_src;
  end

  assign grant_data = (grant_src == GRANT_LSB) ? lsb_head : alu_head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q    <= GRANT_LSB;
      cdb_valid_q     <= 1'b0;
      cdb_src_q       <= GRANT_ALU;
      cdb_rob_entry_q <= '0;
      cdb_value_q     <= '0;
    end else if (rdy) begin
      last_grant_q <= last_grant_d;
      if (grant_valid) begin
        cdb_valid_q     <= 1'b1;
        cdb_src_q       <= grant_src;
        cdb_rob_entry_q <= grant_data.rob_entry;
        cdb_value_q     <= grant_data.value;
      end else begin
        cdb_valid_q     <= 1'b0;
        cdb_src_q       <= GRANT_ALU;
        cdb_rob_entry_q <= '0;
        cdb_value_q     <= '0;
      end
    end
  end

  assign bus.alu_ready     = alu_ready;
  assign bus.lsb_ready     = lsb_ready;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_src       = cdb_src_q;
  assign bus.cdb_rob_entry = cdb_rob_entry_q;
  assign bus.cdb_value     = cdb_value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a directed vector table, hand
// sequences for the multi-cycle corners, and a randomized phase, all
// compared against a queue-based reference of the two source queues.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  logic rollback = 1'b0;

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference: contents of each source queue plus the expected broadcast.
  cdb_entry_t aq[$];
  cdb_entry_t lq[$];
  bit          mlast;
  logic        e_cv, e_src;
  logic [3:0]  e_ent;
  logic [31:0] e_val;
  bit model_ok = 1'b0;
  bit acc_a, acc_l;
  int n_acc_a, n_bc_a;

  typedef struct {
    bit r, rd, rb, av;
    logic [3:0]  ae;
    logic [31:0] avl;
    bit lv;
    logic [3:0]  le;
    logic [31:0] lvl;
    bit cv, src;
    logic [3:0]  ent;
    logic [31:0] val;
    bit ar, lr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit rd, input bit rb,
                      input bit av, input logic [3:0] ae, input logic [31:0] avl,
                      input bit lv, input logic [3:0] le, input logic [31:0] lvl);
    cdb_entry_t it;
    bit a_ok, l_ok, g_ok, g;
    rst = r; rdy = rd; rollback = rb;
    bus.alu_valid = av; bus.alu_rob_entry = ae; bus.alu_value = avl;
    bus.lsb_valid = lv; bus.lsb_rob_entry = le; bus.lsb_value = lvl;
    if (model_ok) begin
      chk("alu_ready", bus.alu_ready, 32'(aq.size() < 2));
      chk("lsb_ready", bus.lsb_ready, 32'(lq.size() < 2));
    end
    acc_a = 1'b0; acc_l = 1'b0;
    if (!r) begin
      aq.delete(); lq.delete();
      mlast = 1'b1;
      e_cv = 0; e_src = 0; e_ent = '0; e_val = '0;
      model_ok = 1'b1;
    end else if (rd) begin
      if (rb) begin
        aq.delete(); lq.delete();
        e_cv = 0; e_src = 0; e_ent = '0; e_val = '0;
      end else begin
        a_ok = av && (aq.size() < 2);
        l_ok = lv && (lq.size() < 2);
        g_ok = (aq.size() != 0) || (lq.size() != 0);
        if (aq.size() != 0 && lq.size() != 0) g = ~mlast;
        else g = (aq.size() == 0);
        if (g_ok) begin
          it = g ? lq.pop_front() : aq.pop_front();
          e_cv = 1; e_src = g; e_ent = it.rob_entry; e_val = it.value;
          mlast = g;
        end else begin
          e_cv = 0; e_src = 0; e_ent = '0; e_val = '0;
        end
        if (a_ok) begin aq.push_back('{rob_entry: ae, value: avl}); acc_a = 1'b1; n_acc_a++; end
        if (l_ok) begin lq.push_back('{rob_entry: le, value: lvl}); acc_l = 1'b1; end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (model_ok) begin
      chk("cdb_valid", bus.cdb_valid, e_cv);
      chk("cdb_src", bus.cdb_src, e_src);
      chk("cdb_rob_entry", bus.cdb_rob_entry, e_ent);
      chk("cdb_value", bus.cdb_value, e_val);
    end
    if (bus.cdb_valid === 1'b1 && bus.cdb_src === 1'b0) n_bc_a++;
  endtask

  task automatic idle();
    step(1, 1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
  endtask

  task automatic reset_cycle();
    step(0, 1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
  endtask

  // Both sources offer fresh results for three edges; leaves 3 entries queued.
  task automatic fill3(input logic [31:0] base);
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, 4'(i + 1), base + 32'(i), 1, 4'(i + 8), base + 32'h10 + 32'(i));
  endtask

  task automatic chk_cdb(input string name, input bit cv, input bit src,
                         input logic [3:0] ent, input logic [31:0] val);
    chk({name, "_valid"}, bus.cdb_valid, cv);
    chk({name, "_src"}, bus.cdb_src, src);
    chk({name, "_entry"}, bus.cdb_rob_entry, ent);
    chk({name, "_value"}, bus.cdb_value, val);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_full;
    int aidx;
    bus.alu_valid = 0; bus.alu_rob_entry = '0; bus.alu_value = '0;
    bus.lsb_valid = 0; bus.lsb_rob_entry = '0; bus.lsb_value = '0;

    //           r rd rb av ae    avl    lv le    lvl    cv src ent  val    ar lr
    tbl[0]  = '{0, 1, 0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  0, 0, 4'h0, 32'h0,  1, 1};
    tbl[1]  = '{1, 1, 0, 1, 4'h3, 32'h11, 0, 4'h0, 32'h0,  0, 0, 4'h0, 32'h0,  1, 1};
    tbl[2]  = '{1, 1, 0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  1, 0, 4'h3, 32'h11, 1, 1};
    tbl[3]  = '{1, 1, 0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  0, 0, 4'h0, 32'h0,  1, 1};
    tbl[4]  = '{0, 1, 1, 1, 4'h7, 32'h77, 1, 4'h6, 32'h66, 0, 0, 4'h0, 32'h0,  1, 1};
    tbl[5]  = '{1, 1, 0, 1, 4'h1, 32'hA,  1, 4'h2, 32'hB,  0, 0, 4'h0, 32'h0,  1, 1};
    tbl[6]  = '{1, 1, 0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  1, 0, 4'h1, 32'hA,  1, 1};
    tbl[7]  = '{1, 1, 0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  1, 1, 4'h2, 32'hB,  1, 1};
    tbl[8]  = '{1, 1, 0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  0, 0, 4'h0, 32'h0,  1, 1};
    tbl[9]  = '{1, 0, 1, 1, 4'h9, 32'h99, 1, 4'h9, 32'h99, 0, 0, 4'h0, 32'h0,  1, 1};
    tbl[10] = '{1, 1, 0, 0, 4'h0, 32'h0,  0, 4'h0, 32'h0,  0, 0, 4'h0, 32'h0,  1, 1};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].rd, tbl[i].rb, tbl[i].av, tbl[i].ae, tbl[i].avl,
           tbl[i].lv, tbl[i].le, tbl[i].lvl);
      chk_cdb($sformatf("tbl%0d", i), tbl[i].cv, tbl[i].src, tbl[i].ent, tbl[i].val);
      chk($sformatf("tbl%0d_alu_ready", i), bus.alu_ready, tbl[i].ar);
      chk($sformatf("tbl%0d_lsb_ready", i), bus.lsb_ready, tbl[i].lr);
    end

    // Backpressure: ALU holds its offer until accepted while LSB also offers.
    reset_cycle();
    n_acc_a = 0; n_bc_a = 0; saw_full = 0; aidx = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.alu_ready === 1'b0) saw_full = 1'b1;
      step(1, 1, 0, 1, 4'(aidx + 1), 32'hA00 + 32'(aidx), 1, 4'(c), 32'hB00 + 32'(c));
      if (acc_a) aidx++;
    end
    for (int c = 0; c < 5; c++) idle();
    chk("bp_alu_full_seen", 32'(saw_full), 1);
    chk("bp_alu_broadcasts", n_bc_a, n_acc_a);

    // rdy freeze while {5,0x55} is on the bus.
    reset_cycle();
    step(1, 1, 0, 1, 4'h5, 32'h55, 1, 4'h6, 32'h66);
    idle();
    chk_cdb("frz_pre", 1, 0, 4'h5, 32'h55);
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 0, 1, 4'h7, 32'h77, 1, 4'h8, 32'h88);
      chk_cdb($sformatf("frz_hold%0d", c), 1, 0, 4'h5, 32'h55);
    end
    idle();
    chk_cdb("frz_resume", 1, 1, 4'h6, 32'h66);
    idle();
    chk_cdb("frz_done", 0, 0, 4'h0, 32'h0);

    // Rollback with entries queued and offers present on the flush edge.
    reset_cycle();
    fill3(32'h100);
    step(1, 1, 1, 1, 4'hE, 32'hEE, 1, 4'hF, 32'hFF);
    chk_cdb("rb_flush", 0, 0, 4'h0, 32'h0);
    chk("rb_alu_ready", bus.alu_ready, 1);
    chk("rb_lsb_ready", bus.lsb_ready, 1);
    for (int c = 0; c < 4; c++) begin
      idle();
      chk($sformatf("rb_no_stale%0d", c), bus.cdb_valid, 0);
    end

    // Reset mid-stream overrides rollback and restores ALU tie priority.
    reset_cycle();
    fill3(32'h200);
    step(0, 1, 1, 1, 4'hC, 32'hCC, 1, 4'hD, 32'hDD);
    chk_cdb("mid_rst", 0, 0, 4'h0, 32'h0);
    step(1, 1, 0, 1, 4'h1, 32'h31, 1, 4'h2, 32'h32);
    idle();
    chk_cdb("mid_tie_alu", 1, 0, 4'h1, 32'h31);
    idle();
    chk_cdb("mid_tie_lsb", 1, 1, 4'h2, 32'h32);

    // Randomized traffic against the reference queues.
    reset_cycle();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
           $urandom_range(0, 1) == 1, 4'($urandom), $urandom);
    end
    for (int c = 0; c < 5; c++) idle();
    chk("drain_valid", bus.cdb_valid, 0);
    chk("drain_alu_ready", bus.alu_ready, 1);
    chk("drain_lsb_ready", bus.lsb_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
